scrambler_descrambler: RTL and testbench

- Self-synchronizing (multiplicative) scrambler/descrambler for a parallel NBITS-wide data path, with the mode selected by parameter.
- A scrambler instance (CHK_MODE=0) feeds the line; a descrambler instance (CHK_MODE=1) at the receiver recovers the data.
- Both instances use the same polynomial and seed.
- A channel bit error corrupts only a bounded burst of output, after which the descrambler recovers on its own.

---
 rtl/scrambler_pkg.sv | 70 +++++++
 rtl/scrambler_descrambler_if.sv | 28 ++
 rtl/scrambler_step.sv | 40 ++++
 rtl/scrambler_descrambler.sv | 65 ++++++
 tb/tb_scrambler_descrambler.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/scrambler_pkg.sv
// -----------------------------------------------------------------------------
// scrambler_pkg
// Shared constants and the word-level step function for the self-synchronizing
// (multiplicative) scrambler/descrambler.
//   DEFAULT_TAPS  : x^16 + x^5 + x^4 + x^3 + 1 (bit k-1 set = delay k tapped)
//   DEFAULT_SEED  : all-ones history value loaded on reset
//   scramble_word : one NBITS word through the history register, either mode
// The step function works on fixed maximum-width vectors so that it can be
// shared by any POLY_LENGHT <= MAX_POLY and NBITS <= MAX_NBITS; unused upper
// bits are masked to zero and fold away once the length arguments are
// constants.
// -----------------------------------------------------------------------------
package scrambler_pkg;

    localparam int MAX_POLY  = 64;
    localparam int MAX_NBITS = 64;

    localparam logic [15:0] DEFAULT_TAPS = 16'h801C;
    localparam logic [15:0] DEFAULT_SEED = 16'hFFFF;

    typedef enum logic {
        MODE_SCRAMBLE   = 1'b0,
        MODE_DESCRAMBLE = 1'b1
    } chk_mode_e;

    typedef struct packed {
        logic [MAX_POLY-1:0]  hist;
        logic [MAX_NBITS-1:0] word;
    } step_result_t;

    // Bit 0 of the word is the oldest bit in time, so it is processed first.
    // hist[0] is delay 1 (most recent line bit).
    function automatic step_result_t scramble_word(
        input chk_mode_e             mode,
        input int                    poly_len,
        input int                    nbits,
        input logic [MAX_POLY-1:0]   taps,
        input logic [MAX_POLY-1:0]   hist_in,
        input logic [MAX_NBITS-1:0]  word_in
    );
        step_result_t        res;
        logic [MAX_POLY-1:0] hist;
        logic [MAX_POLY-1:0] len_mask;
        logic                fb;
        logic                o;
        logic                line_bit;

        len_mask = '0;
        for (int k = 0; k < MAX_POLY; k++) begin
            if (k < poly_len) len_mask[k] = 1'b1;
        end

        hist     = hist_in & len_mask;
        res.word = '0;
        for (int i = 0; i < MAX_NBITS; i++) begin
            if (i < nbits) begin
                fb          = ^(hist & taps & len_mask);
                o           = word_in[i] ^ fb;
                res.word[i] = o;
                // The history always tracks the line: scrambler output on the
                // transmit side, the received bit on the receive side.
                line_bit    = (mode == MODE_DESCRAMBLE) ? word_in[i] : o;
                hist        = {hist[MAX_POLY-2:0], line_bit} & len_mask;
            end
        end
        res.hist = hist;
        return res;
    endfunction

endpackage

// File: rtl/scrambler_descrambler_if.sv
// -----------------------------------------------------------------------------
// scrambler_descrambler_if
// Data path bundle for one scrambler or descrambler instance.
//   DATA_IN  : NBITS word to process
//   EN       : word valid; the block advances only when EN=1 (no back-pressure,
//              EN is a plain qualifier: a word is consumed on every rising edge
//              where EN=1 and reset is low)
//   DATA_OUT : registered result, one cycle after the accepted word
//   BYPASS   : only with SCRAMBLER_BYPASS_EN; passes DATA_IN through, history
//              held
// master = the producer driving words in, slave = the scrambler block.
// -----------------------------------------------------------------------------
interface scrambler_descrambler_if #(
    parameter int NBITS = 8
);
    logic [NBITS-1:0] DATA_IN;
    logic             EN;
    logic [NBITS-1:0] DATA_OUT;
`ifdef SCRAMBLER_BYPASS_EN
    logic             BYPASS;

    modport master (output DATA_IN, output EN, output BYPASS, input DATA_OUT);
    modport slave  (input DATA_IN, input EN, input BYPASS, output DATA_OUT);
`else
    modport master (output DATA_IN, output EN, input DATA_OUT);
    modport slave  (input DATA_IN, input EN, output DATA_OUT);
`endif
endinterface

// File: rtl/scrambler_step.sv
// -----------------------------------------------------------------------------
// scrambler_step
// Purely combinational one-word step: all NBITS per-bit steps chained.
//   hist_in  : current history register (hist_in[0] = delay 1)
//   word_in  : word to scramble / received word to descramble
//   hist_nxt : history after the word
//   word_out : result word
// Valid for NBITS both larger and smaller than POLY_LENGHT (each limited to 64).
// -----------------------------------------------------------------------------
module scrambler_step
    import scrambler_pkg::*;
#(
    parameter int                     CHK_MODE    = 0,
    parameter int                     POLY_LENGHT = 16,
    parameter int                     NBITS       = 8,
    parameter logic [POLY_LENGHT-1:0] TAPS        = POLY_LENGHT'(DEFAULT_TAPS)
) (
    input  logic [POLY_LENGHT-1:0] hist_in,
    input  logic [NBITS-1:0]       word_in,
    output logic [POLY_LENGHT-1:0] hist_nxt,
    output logic [NBITS-1:0]       word_out
);

    localparam chk_mode_e MODE = (CHK_MODE != 0) ? MODE_DESCRAMBLE : MODE_SCRAMBLE;

    step_result_t res;
    logic         unused_res;

    assign res = scramble_word(MODE, POLY_LENGHT, NBITS,
                               MAX_POLY'(TAPS),
                               MAX_POLY'(hist_in),
                               MAX_NBITS'(word_in));

    assign hist_nxt = res.hist[POLY_LENGHT-1:0];
    assign word_out = res.word[NBITS-1:0];

    // Upper bits of the wide result are always zero.
    assign unused_res = ^res;

endmodule

// File: rtl/scrambler_descrambler.sv
// -----------------------------------------------------------------------------
// scrambler_descrambler
// Self-synchronizing multiplicative scrambler (CHK_MODE=0) or descrambler
// (CHK_MODE=1) on an NBITS-wide parallel path, one word per enabled clock.
//   CLK  : rising-edge clock
//   RST  : synchronous, active-high; loads SEED into history, clears DATA_OUT,
//          and wins over EN
//   bus  : scrambler_descrambler_if.slave (DATA_IN, EN, DATA_OUT[, BYPASS])
// Latency is one cycle: a word accepted at edge k is on DATA_OUT after it.
// Optional macro SCRAMBLER_BYPASS_EN adds BYPASS: with EN=1 and BYPASS=1 the
// input word is registered unchanged and the history holds.
// -----------------------------------------------------------------------------
module scrambler_descrambler
    import scrambler_pkg::*;
#(
    parameter int                     CHK_MODE    = 0,
    parameter int                     POLY_LENGHT = 16,
    parameter int                     NBITS       = 8,
    parameter logic [POLY_LENGHT-1:0] TAPS        = POLY_LENGHT'(DEFAULT_TAPS),
    parameter logic [POLY_LENGHT-1:0] SEED        = {POLY_LENGHT{1'b1}}
) (
    input  logic                  CLK,
    input  logic                  RST,
    scrambler_descrambler_if.slave bus
);

    logic [POLY_LENGHT-1:0] hist_q;
    logic [POLY_LENGHT-1:0] hist_nxt;
    logic [NBITS-1:0]       dout_q;
    logic [NBITS-1:0]       word_res;

    scrambler_step #(
        .CHK_MODE    (CHK_MODE),
        .POLY_LENGHT (POLY_LENGHT),
        .NBITS       (NBITS),
        .TAPS        (TAPS)
    ) u_step (
        .hist_in  (hist_q),
        .word_in  (bus.DATA_IN),
        .hist_nxt (hist_nxt),
        .word_out (word_res)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            hist_q <= SEED;
            dout_q <= '0;
        end else if (bus.EN) begin
`ifdef SCRAMBLER_BYPASS_EN
            if (bus.BYPASS) begin
                dout_q <= bus.DATA_IN;
            end else begin
                dout_q <= word_res;
                hist_q <= hist_nxt;
            end
`else
            dout_q <= word_res;
            hist_q <= hist_nxt;
`endif
        end
    end

    assign bus.DATA_OUT = dout_q;

endmodule

// File: tb/tb_scrambler_descrambler.sv
module tb_scrambler_descrambler;
    import scrambler_pkg::*;

    localparam int N = 8;
    localparam int P = 16;
    localparam logic [P-1:0] TAPS_V = 16'h801C;
    localparam logic [P-1:0] SEED_V = 16'hFFFF;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic rst0 = 1'b0;
    always #5 clk = ~clk;

    scrambler_descrambler_if #(.NBITS(N)) scr_if  ();
    scrambler_descrambler_if #(.NBITS(N)) dsc_if  ();
    scrambler_descrambler_if #(.NBITS(N)) scr0_if ();
    scrambler_descrambler_if #(.NBITS(N)) dsc0_if ();

    // Chained pair with default seed; the receiver is enabled one cycle after
    // the transmitter, when the scrambled word is on the line.
    scrambler_descrambler #(.CHK_MODE(0)) u_scr (.CLK(clk), .RST(rst), .bus(scr_if.slave));
    scrambler_descrambler #(.CHK_MODE(1)) u_dsc (.CLK(clk), .RST(rst), .bus(dsc_if.slave));
    // Independent zero-seed pair for the directed table.
    scrambler_descrambler #(.CHK_MODE(0), .SEED(16'h0000)) u_scr0 (.CLK(clk), .RST(rst0), .bus(scr0_if.slave));
    scrambler_descrambler #(.CHK_MODE(1), .SEED(16'h0000)) u_dsc0 (.CLK(clk), .RST(rst0), .bus(dsc0_if.slave));

    logic         en_d     = 1'b0;
    logic [N-1:0] line_err = '0;
    always @(posedge clk) en_d <= rst ? 1'b0 : scr_if.EN;
    assign dsc_if.EN      = en_d;
    assign dsc_if.DATA_IN = scr_if.DATA_OUT ^ line_err;

    // ---------------- scoreboard state ----------------
    int           errors = 0;
    int           checks = 0;
    logic [N-1:0] exp_q[$];
    bit           line_hist[$];   // transmitted line bits, oldest first
    int           err_bits[$];    // absolute descrambled bit positions expected corrupt
    int           dsc_bits = 0;
    int           dsc_idx  = 0;
    int           first_bad = -1;
    int           last_bad  = -1;
    logic [N-1:0] model_out = '0;
    logic [N-1:0] dsc_exp_out = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model_reset(input logic [P-1:0] seed);
        line_hist.delete();
        for (int k = P; k >= 1; k--) line_hist.push_back(seed[k-1]);
    endfunction

    function automatic logic [N-1:0] model_scramble(input logic [N-1:0] d);
        logic [N-1:0] w;
        bit fb;
        w = '0;
        for (int i = 0; i < N; i++) begin
            fb = 1'b0;
            for (int k = 1; k <= P; k++)
                if (TAPS_V[k-1]) fb ^= line_hist[line_hist.size() - k];
            w[i] = d[i] ^ fb;
            line_hist.push_back(w[i]);
            void'(line_hist.pop_front());
        end
        return w;
    endfunction

    function automatic logic [P-1:0] model_h();
        logic [P-1:0] h;
        for (int k = 1; k <= P; k++) h[k-1] = line_hist[line_hist.size() - k];
        return h;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic en, input logic [N-1:0] d);
        scr_if.EN      = en;
        scr_if.DATA_IN = d;
    endtask

    task automatic tick(input string tag);
        logic dv, sv;
        logic [N-1:0] clean, mask;
        dv = en_d && !rst;
        sv = scr_if.EN && !rst;
        if (dv && line_err != '0) begin
            for (int b = 0; b < N; b++) begin
                if (line_err[b]) begin
                    err_bits.push_back(dsc_bits + b);
                    for (int k = 1; k <= P; k++)
                        if (TAPS_V[k-1]) err_bits.push_back(dsc_bits + b + k);
                end
            end
        end
        if (sv) begin
            model_out = model_scramble(scr_if.DATA_IN);
            exp_q.push_back(scr_if.DATA_IN);
        end
        if (rst) begin
            model_reset(SEED_V);
            model_out = '0;
        end
        @(posedge clk);
        #1;
        check({tag, "_scr_out"}, 64'(scr_if.DATA_OUT), 64'(model_out));
        check({tag, "_scr_hist"}, 64'(u_scr.hist_q), 64'(model_h()));
        if (rst) begin
            exp_q.delete();
            dsc_idx     = 0;
            dsc_exp_out = '0;
            check({tag, "_dsc_rst_out"}, 64'(dsc_if.DATA_OUT), 64'(0));
            check({tag, "_dsc_rst_hist"}, 64'(u_dsc.hist_q), 64'(SEED_V));
        end else if (dv) begin
            if (exp_q.size() == 0) begin
                check({tag, "_dsc_underflow"}, 64'(1), 64'(0));
            end else begin
                clean = exp_q.pop_front();
                mask  = '0;
                for (int b = 0; b < N; b++)
                    foreach (err_bits[j]) if (err_bits[j] == dsc_bits + b) mask[b] = ~mask[b];
                dsc_exp_out = clean ^ mask;
                dsc_idx++;
                if (dsc_if.DATA_OUT !== clean) begin
                    if (first_bad < 0) first_bad = dsc_idx;
                    last_bad = dsc_idx;
                end
                check({tag, "_dsc_out"}, 64'(dsc_if.DATA_OUT), 64'(dsc_exp_out));
            end
            dsc_bits += N;
        end else begin
            check({tag, "_dsc_hold"}, 64'(dsc_if.DATA_OUT), 64'(dsc_exp_out));
        end
    endtask

    // ---------------- directed table for the zero-seed pair ----------------
    typedef struct {
        logic         rst;
        logic         en;
        logic [N-1:0] din_s;
        logic [N-1:0] exp_s;
        logic [N-1:0] din_d;
        logic [N-1:0] exp_d;
        logic [P-1:0] exp_h;
    } vec_t;

    vec_t vecs[6];

    initial begin
`ifdef SCRAMBLER_BYPASS_EN
        scr_if.BYPASS  = 1'b0;
        dsc_if.BYPASS  = 1'b0;
        scr0_if.BYPASS = 1'b0;
        dsc0_if.BYPASS = 1'b0;
`endif
        vecs[0] = '{1'b1, 1'b0, 8'hAA, 8'h00, 8'hAA, 8'h00, 16'h0000}; // reset state
        vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000}; // zero in, zero out
        vecs[2] = '{1'b0, 1'b1, 8'h01, 8'h79, 8'h79, 8'h01, 16'h009E}; // first-word vector
        vecs[3] = '{1'b0, 1'b0, 8'h55, 8'h79, 8'h33, 8'h01, 16'h009E}; // EN=0 holds
        vecs[4] = '{1'b1, 1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00, 16'h0000}; // reset beats EN
        vecs[5] = '{1'b0, 1'b1, 8'h01, 8'h79, 8'h79, 8'h01, 16'h009E}; // restart from seed

        drive(1'b0, '0);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rst0            = vecs[i].rst;
            scr0_if.EN      = vecs[i].en;
            dsc0_if.EN      = vecs[i].en;
            scr0_if.DATA_IN = vecs[i].din_s;
            dsc0_if.DATA_IN = vecs[i].din_d;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_scr0_out", i), 64'(scr0_if.DATA_OUT), 64'(vecs[i].exp_s));
            check($sformatf("vec%0d_dsc0_out", i), 64'(dsc0_if.DATA_OUT), 64'(vecs[i].exp_d));
            check($sformatf("vec%0d_scr0_hist", i), 64'(u_scr0.hist_q), 64'(vecs[i].exp_h));
            check($sformatf("vec%0d_dsc0_hist", i), 64'(u_dsc0.hist_q), 64'(vecs[i].exp_h));
        end
        rst0       = 1'b0;
        scr0_if.EN = 1'b0;
        dsc0_if.EN = 1'b0;

        // ---------------- chained pair ----------------
        rst = 1'b1;
        tick("reset");
        rst = 1'b0;

        // Counter 01..1E, clean channel.
        for (int w = 1; w <= 30; w++) begin
            drive(1'b1, N'(w));
            tick("count");
        end
        check("count_clean", 64'(first_bad), 64'(-1));

        // One line bit flipped while word 31 is on the line.
        for (int w = 31; w <= 66; w++) begin
            line_err = (w == 32) ? 8'h01 : 8'h00;
            drive(1'b1, N'(w));
            tick("burst");
        end
        line_err = '0;
        check("burst_first_word", 64'(first_bad), 64'(31));
        check("burst_span_le3", 64'(last_bad - first_bad <= 2), 64'(1));

        // EN low for five cycles mid-stream.
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, N'($urandom_range(0, 255)));
            tick("freeze");
        end
        for (int w = 67; w <= 76; w++) begin
            drive(1'b1, N'(w));
            tick("resume");
        end

        // Reset for one edge mid-stream, EN held high.
        rst = 1'b1;
        drive(1'b1, 8'hC3);
        tick("midrst");
        rst = 1'b0;
        first_bad = -1;
        for (int w = 0; w < 10; w++) begin
            drive(1'b1, N'(8'h40 + w));
            tick("postrst");
        end
        check("postrst_clean", 64'(first_bad), 64'(-1));

        // Random data with random EN gaps.
        for (int c = 0; c < 150; c++) begin
            drive(($urandom_range(0, 3) != 0), N'($urandom_range(0, 255)));
            tick("rand");
        end
        check("rand_clean", 64'(first_bad), 64'(-1));

        drive(1'b0, '0);
        tick("drain");
        tick("drain");
        check("drain_empty", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
